// File: rtl/menu_cmd_decoder_if.sv
// Bundle of cursor/keypad inputs and command outputs for the grid-menu decoder.
// The decoder uses the slave view; the cursor logic/consumer side uses master.
interface menu_cmd_decoder_if #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int CMD_W = 8,
  parameter int IDX_W = 3
);
  logic             enter;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             ack;
  logic [CMD_W-1:0] command;
  logic [7:0]       offset;
  logic [IDX_W-1:0] cmd_index;
  logic             cmd_valid;
  logic             busy;
  logic             miss;
  logic             timeout;

  modport master (
    output enter, x, y, ack,
    input  command, offset, cmd_index, cmd_valid, busy, miss, timeout
  );

  modport slave (
    input  enter, x, y, ack,
    output command, offset, cmd_index, cmd_valid, busy, miss, timeout
  );
endinterface

// File: rtl/menu_cmd_decoder.sv
// Grid-menu command decoder: on an enter rising edge, matches the cursor against
// a NUM_COLS x NUM_ROWS slot grid and issues a held one-hot command until ack/timeout.
module menu_cmd_decoder #(
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int NUM_COLS    = 4,
  parameter int NUM_ROWS    = 2,
  parameter int X0          = 8,
  parameter int Y0          = 22,
  parameter int XSTEP       = 40,
  parameter int YSTEP       = 40,
  parameter logic [7:0] OFF_SET = 8'h20,
  parameter logic [NUM_COLS*NUM_ROWS-1:0] ENABLE_MASK = 8'b1111_1100,
  parameter int ACK_TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  menu_cmd_decoder_if.slave bus
);
  localparam int CMD_W = NUM_COLS * NUM_ROWS;
  localparam int IDX_W = (CMD_W > 1) ? $clog2(CMD_W) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic             enter_q_r;
  logic [31:0]      timer_r, timer_s;
  logic [CMD_W-1:0] command_r, command_s;
  logic [7:0]       offset_r, offset_s;
  logic [IDX_W-1:0] cmd_index_r, cmd_index_s;
  logic             cmd_valid_r, cmd_valid_s;
  logic             busy_r, busy_s;
  logic             miss_r, miss_s;
  logic             timeout_r, timeout_s;

  logic             rise_s;
  logic             slot_ok_s;
  logic [IDX_W-1:0] slot_s;
  logic [7:0]       row_off_s;

  assign rise_s = bus.enter & ~enter_q_r;

  // Slot decode: exact 32-bit coordinate match against each enabled grid slot
  always_comb begin
    slot_ok_s = 1'b0;
    slot_s    = {IDX_W{1'b0}};
    row_off_s = 8'h00;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if ((32'(bus.x) == 32'(X0 + c * XSTEP)) &&
            (32'(bus.y) == 32'(Y0 + r * YSTEP)) &&
            ENABLE_MASK[r * NUM_COLS + c]) begin
          slot_ok_s = 1'b1;
          slot_s    = IDX_W'(r * NUM_COLS + c);
          row_off_s = 8'(r * OFF_SET);
        end else begin
          slot_ok_s = slot_ok_s;
        end
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    timer_s     = timer_r;
    command_s   = command_r;
    offset_s    = offset_r;
    cmd_index_s = cmd_index_r;
    cmd_valid_s = 1'b0;
    miss_s      = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        timer_s = 32'd0;
        if (rise_s) begin
          if (slot_ok_s) begin
            command_s   = CMD_W'(1) << slot_s;
            cmd_index_s = slot_s;
            offset_s    = row_off_s;
            cmd_valid_s = 1'b1;
            state_s     = WAIT_ACK;
          end else begin
            miss_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_ACK: begin
        timer_s = timer_r + 32'd1;
        // ack has priority over a timeout expiring in the same cycle
        if (bus.ack) begin
          command_s   = {CMD_W{1'b0}};
          offset_s    = 8'h00;
          cmd_index_s = {IDX_W{1'b0}};
          state_s     = RELEASE;
        end else if ((ACK_TIMEOUT != 0) && (timer_r == 32'(ACK_TIMEOUT - 1))) begin
          command_s   = {CMD_W{1'b0}};
          offset_s    = 8'h00;
          cmd_index_s = {IDX_W{1'b0}};
          timeout_s   = 1'b1;
          state_s     = RELEASE;
        end else begin
          state_s = WAIT_ACK;
        end
      end
      RELEASE: begin
        timer_s = 32'd0;
        if (!bus.enter) begin
          state_s = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end
      default: begin
        state_s     = IDLE;
        timer_s     = 32'd0;
        command_s   = {CMD_W{1'b0}};
        offset_s    = 8'h00;
        cmd_index_s = {IDX_W{1'b0}};
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      enter_q_r   <= 1'b0;
      timer_r     <= 32'd0;
      command_r   <= {CMD_W{1'b0}};
      offset_r    <= 8'h00;
      cmd_index_r <= {IDX_W{1'b0}};
      cmd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      miss_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      enter_q_r   <= bus.enter;
      timer_r     <= timer_s;
      command_r   <= command_s;
      offset_r    <= offset_s;
      cmd_index_r <= cmd_index_s;
      cmd_valid_r <= cmd_valid_s;
      busy_r      <= busy_s;
      miss_r      <= miss_s;
      timeout_r   <= timeout_s;
    end
  end

  assign bus.command   = command_r;
  assign bus.offset    = offset_r;
  assign bus.cmd_index = cmd_index_r;
  assign bus.cmd_valid = cmd_valid_r;
  assign bus.busy      = busy_r;
  assign bus.miss      = miss_r;
  assign bus.timeout   = timeout_r;
endmodule

// File: tb/tb_menu_cmd_decoder.sv
// Scoreboard bench for menu_cmd_decoder: stimulus pushes expected pulses,
// a negedge monitor pops and compares whenever cmd_valid/miss/timeout appears.
module tb_menu_cmd_decoder;
  localparam int K_CMD = 0;
  localparam int K_MISS = 1;
  localparam int K_TMO = 2;

  typedef struct {
    int         kind;
    logic [7:0] cmd;
    logic [2:0] idx;
    logic [7:0] off;
    int         lat;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   last_valid_cyc;
  exp_t exp_q[$];

  menu_cmd_decoder_if #(.XW(10), .YW(9), .CMD_W(8), .IDX_W(3)) bus ();

  menu_cmd_decoder dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [7:0] cmd, input logic [2:0] idx,
                      input logic [7:0] off, input int lat);
    exp_t e;
    e.kind = kind; e.cmd = cmd; e.idx = idx; e.off = off; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every output pulse against the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   kind;
    int   npulse;
    cyc++;
    npulse = int'(bus.cmd_valid) + int'(bus.miss) + int'(bus.timeout);
    if (npulse > 1) chk("pulse_exclusive", 32'(npulse), 32'd1);
    if (npulse != 0) begin
      kind = bus.cmd_valid ? K_CMD : (bus.miss ? K_MISS : K_TMO);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_kind", 32'(kind), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 32'(kind), 32'(e.kind));
        chk("pulse_command", 32'(bus.command), 32'(e.cmd));
        chk("pulse_cmd_index", 32'(bus.cmd_index), 32'(e.idx));
        chk("pulse_offset", 32'(bus.offset), 32'(e.off));
        if (kind == K_CMD) begin
          chk("busy_with_cmd_valid", 32'(bus.busy), 32'd1);
          last_valid_cyc = cyc;
        end else if (kind == K_MISS) begin
          chk("busy_with_miss", 32'(bus.busy), 32'd0);
        end else begin
          chk("timeout_latency", 32'(cyc - last_valid_cyc), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    int n;
    checks = 0; failures = 0; cyc = 0; last_valid_cyc = 0;
    reset = 1'b1;
    bus.enter = 1'b0; bus.x = 10'd0; bus.y = 9'd0; bus.ack = 1'b0;
    #2;
    chk("reset_command", 32'(bus.command), 32'd0);
    chk("reset_offset", 32'(bus.offset), 32'd0);
    chk("reset_cmd_index", 32'(bus.cmd_index), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_pulses", 32'({bus.cmd_valid, bus.miss, bus.timeout}), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Hit row 0, enter held 5 cycles, ack on 3rd busy cycle
    bus.x = 10'd88; bus.y = 9'd22;
    push(K_CMD, 8'b0000_0100, 3'd2, 8'h00, 0);
    bus.enter = 1'b1;
    tick();
    chk("r0_busy_c1", 32'(bus.busy), 32'd1);
    tick();
    chk("r0_command_held", 32'(bus.command), 32'h04);
    tick();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("r0_cleared_after_ack", 32'(bus.command), 32'd0);
    chk("r0_busy_release", 32'(bus.busy), 32'd1);
    tick();
    chk("r0_busy_release_enter_high", 32'(bus.busy), 32'd1);
    bus.enter = 1'b0;
    tick();
    chk("r0_idle", 32'(bus.busy), 32'd0);

    // Hit row 1, ack immediately
    bus.x = 10'd128; bus.y = 9'd62;
    push(K_CMD, 8'b1000_0000, 3'd7, 8'h20, 0);
    bus.enter = 1'b1;
    tick();
    bus.ack = 1'b1; bus.enter = 1'b0;
    tick();
    bus.ack = 1'b0;
    chk("r1_cmd_valid_one_cycle", 32'(bus.cmd_valid), 32'd0);
    chk("r1_cleared", 32'(bus.offset), 32'd0);
    tick();
    chk("r1_min_busy_idle", 32'(bus.busy), 32'd0);

    // Masked slot 0 and off-grid point both miss
    bus.x = 10'd8; bus.y = 9'd22;
    push(K_MISS, 8'h00, 3'd0, 8'h00, 0);
    bus.enter = 1'b1;
    tick();
    chk("miss_masked_busy", 32'(bus.busy), 32'd0);
    bus.enter = 1'b0;
    tick();
    bus.x = 10'd9; bus.y = 9'd62;
    push(K_MISS, 8'h00, 3'd0, 8'h00, 0);
    bus.enter = 1'b1;
    tick();
    chk("miss_offgrid_busy", 32'(bus.busy), 32'd0);
    bus.enter = 1'b0;
    tick();

    // Timeout: no ack, command held 255 cycles
    bus.x = 10'd48; bus.y = 9'd62;
    push(K_CMD, 8'b0010_0000, 3'd5, 8'h20, 0);
    push(K_TMO, 8'h00, 3'd0, 8'h00, 255);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick();
    chk("tmo_command_held", 32'(bus.command), 32'h20);
    n = 0;
    while (bus.busy && n < 400) begin
      tick();
      n++;
    end
    chk("tmo_returned_idle", 32'(bus.busy), 32'd0);

    // Lockout: rise during WAIT_ACK ignored; RELEASE holds while enter high
    bus.x = 10'd88; bus.y = 9'd22;
    push(K_CMD, 8'b0000_0100, 3'd2, 8'h00, 0);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick();
    bus.x = 10'd88; bus.y = 9'd62;
    bus.enter = 1'b1;
    tick();
    chk("lock_command_kept", 32'(bus.command), 32'h04);
    tick();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick(); tick();
    chk("lock_release_busy", 32'(bus.busy), 32'd1);
    bus.enter = 1'b0;
    tick();
    chk("lock_idle", 32'(bus.busy), 32'd0);
    push(K_CMD, 8'b0100_0000, 3'd6, 8'h20, 0);
    bus.enter = 1'b1;
    tick();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0; bus.enter = 1'b0;
    tick(); tick();

    // Asynchronous reset mid-WAIT_ACK
    bus.x = 10'd128; bus.y = 9'd22;
    push(K_CMD, 8'b0000_1000, 3'd3, 8'h00, 0);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick();
    chk("ar_pre_command", 32'(bus.command), 32'h08);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_command", 32'(bus.command), 32'd0);
    chk("ar_offset", 32'(bus.offset), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("ar_still_idle", 32'(bus.busy), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
